// File: rtl/gecko_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  mem_intf / stream_intf
//  Request bus and valid/ready data stream used by gecko_mem_arbiter.
//  Revision: 1.0
// ============================================================================

interface mem_intf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic                  read_enable;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;

  modport in  (input  valid, read_enable, write_enable, addr, data, output ready);
  modport out (output valid, read_enable, write_enable, addr, data, input  ready);
endinterface

interface stream_intf #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] payload;

  modport in  (input  valid, payload, output ready);
  modport out (output valid, payload, input  ready);
endinterface

`default_nettype wire

// File: rtl/gecko_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  gecko_mem_arbiter
//  Two-port memory request arbiter with read-response routing FIFO.
//  Revision: 1.0
// ============================================================================

module gecko_mem_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIXED_PRIORITY  = 0
) (
  input  logic      clk,
  input  logic      rst,
  mem_intf.in       req0,
  mem_intf.in       req1,
  mem_intf.out      mem_request,
  stream_intf.in    mem_response,
  stream_intf.out   rsp0,
  stream_intf.out   rsp1,
  output logic      unexpected_response
);

  localparam int                 c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_OUTSTANDING);

  // Output register stage
  logic                  r_out_valid;
  logic                  r_out_re;
  logic                  r_out_we;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [DATA_WIDTH-1:0] r_out_data;

  // Arbitration and routing state
  logic                       r_last_grant;
  logic [MAX_OUTSTANDING-1:0] r_fifo_id;
  logic [c_PTR_W-1:0]         r_wr_ptr;
  logic [c_PTR_W-1:0]         r_rd_ptr;
  logic [c_CNT_W-1:0]         r_count;
  logic                       r_unexpected;

  logic                  w_slot_free;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_elig0;
  logic                  w_elig1;
  logic                  w_sel;
  logic                  w_grant;
  logic                  w_sel_re;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_stray;
  logic                  w_head_id;

  assign w_slot_free  = !r_out_valid || mem_request.ready;
  assign w_fifo_full  = (r_count == c_MAX);
  assign w_fifo_empty = (r_count == '0);

  // A full FIFO blocks reads even when a pop happens this cycle.
  assign w_elig0 = rst && req0.valid && w_slot_free && !(req0.read_enable && w_fifo_full);
  assign w_elig1 = rst && req1.valid && w_slot_free && !(req1.read_enable && w_fifo_full);
  assign w_grant = w_elig0 || w_elig1;

  if (FIXED_PRIORITY != 0) begin : g_fixed_prio
    assign w_sel = !w_elig0;
  end else begin : g_round_robin
    always_comb begin
      w_sel = 1'b0;
      if (w_elig0 && w_elig1) begin
        w_sel = !r_last_grant;
      end else if (w_elig1) begin
        w_sel = 1'b1;
      end
    end
  end

  assign req0.ready = w_grant && !w_sel;
  assign req1.ready = w_grant &&  w_sel;

  assign w_sel_re   = w_sel ? req1.read_enable  : req0.read_enable;
  assign w_sel_we   = w_sel ? req1.write_enable : req0.write_enable;
  assign w_sel_addr = w_sel ? req1.addr         : req0.addr;
  assign w_sel_data = w_sel ? req1.data         : req0.data;

  // Combined read+write requests are routed like reads.
  assign w_push = w_grant && w_sel_re;

  assign mem_request.valid        = r_out_valid;
  assign mem_request.read_enable  = r_out_re;
  assign mem_request.write_enable = r_out_we;
  assign mem_request.addr         = r_out_addr;
  assign mem_request.data         = r_out_data;

  assign w_head_id = r_fifo_id[r_rd_ptr];

  always_comb begin
    mem_response.ready = 1'b1;
    rsp0.valid         = 1'b0;
    rsp1.valid         = 1'b0;
    if (rst && !w_fifo_empty) begin
      if (w_head_id) begin
        mem_response.ready = rsp1.ready;
        rsp1.valid         = mem_response.valid;
      end else begin
        mem_response.ready = rsp0.ready;
        rsp0.valid         = mem_response.valid;
      end
    end
  end

  assign rsp0.payload = mem_response.payload;
  assign rsp1.payload = mem_response.payload;

  assign w_pop   = rst && !w_fifo_empty && mem_response.valid && mem_response.ready;
  assign w_stray = rst &&  w_fifo_empty && mem_response.valid;

  assign unexpected_response = r_unexpected;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_re    <= 1'b0;
      r_out_we    <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
    end else if (w_grant) begin
      r_out_valid <= 1'b1;
      r_out_re    <= w_sel_re;
      r_out_we    <= w_sel_we;
      r_out_addr  <= w_sel_addr;
      r_out_data  <= w_sel_data;
    end else if (mem_request.ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // last_grant resets to port 1 so port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_grant <= 1'b1;
    end else if (w_grant) begin
      r_last_grant <= w_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fifo_id <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      if (w_push) begin
        r_fifo_id[r_wr_ptr] <= w_sel;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_unexpected <= 1'b0;
    end else if (w_stray) begin
      r_unexpected <= 1'b1;
    end
  end

endmodule

`default_nettype wire
